// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline interlock controller.
package pipe_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned PCSRC_W = 2;
    localparam int unsigned INSTR_W = 32;

    // Decode PC select: sequential fetch; any other code is a redirect
    localparam logic [PCSRC_W-1:0] PC_SEQ = 2'b00;

    // Instruction word loaded into a pipeline register when it is bubbled
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    // One in-flight destination register
    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] wa;
    } sb_entry_t;

    // Which priority class the current cycle resolves to
    typedef enum logic [2:0] {
        RES_RUN,
        RES_RESET,
        RES_HOLD,
        RES_STALL,
        RES_FLUSH
    } ctrl_res_t;

    // True when a valid in-flight entry writes register r
    function automatic logic sb_match(input sb_entry_t e, input logic [REG_W-1:0] r);
        return e.v && (e.wa == r);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side bus between the fetch/decode datapath and the interlock controller.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    import pipe_pkg::*;

    logic               id_valid;
    logic [REG_W-1:0]   id_rs;
    logic [REG_W-1:0]   id_rt;
    logic               id_use_rs;
    logic               id_use_rt;
    logic [REG_W-1:0]   id_wa;
    logic               id_wrf;
    logic [PCSRC_W-1:0] id_pcsource;
    logic               mem_hold;

    logic               pc_en;
    logic               ifid_en;
    logic               ifid_flush;
    logic               idex_bubble;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    // Datapath side: presents decode info, consumes pipeline controls
    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wa, id_wrf, id_pcsource, mem_hold,
        input  pc_en, ifid_en, ifid_flush, idex_bubble, stall_cnt, flush_cnt
    );

    // Controller side
    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wa, id_wrf, id_pcsource, mem_hold,
        output pc_en, ifid_en, ifid_flush, idex_bubble, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    // Count up on inc until the ceiling is reached
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline interlock controller: tracks EX/MEM/WB destinations and sequences
// PC / IF/ID / ID/EX for RAW stalls, decode redirects and memory-bus holds.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter bit          DELAY_SLOT = 1'b1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave hz
);

    sb_entry_t  r_sb_ex;
    sb_entry_t  r_sb_mem;
    sb_entry_t  r_sb_wb;
    sb_entry_t  w_sb_ex_nxt;

    logic       w_match_rs;
    logic       w_match_rt;
    logic       w_haz;
    logic       w_redir;
    ctrl_res_t  w_res;

    logic       w_pc_en;
    logic       w_ifid_en;
    logic       w_ifid_flush;
    logic       w_idex_bubble;

    logic       w_stall_inc;
    logic       w_flush_inc;
    logic [CNT_W-1:0] w_stall_cnt;
    logic [CNT_W-1:0] w_flush_cnt;
    logic       w_unused;

    // RAW hazard against EX/MEM; WB is written on the falling edge so it never conflicts
    always_comb begin
        w_match_rs = sb_match(r_sb_ex, hz.id_rs) | sb_match(r_sb_mem, hz.id_rs);
        w_match_rt = sb_match(r_sb_ex, hz.id_rt) | sb_match(r_sb_mem, hz.id_rt);
        w_haz      = hz.id_valid &
                     ((hz.id_use_rs & (hz.id_rs != '0) & w_match_rs) |
                      (hz.id_use_rt & (hz.id_rt != '0) & w_match_rt));
        // A redirect evaluated on stale operands is ignored until the stall clears
        w_redir    = hz.id_valid & (hz.id_pcsource != PC_SEQ) & ~w_haz;
    end

    // Resolve the cycle to a single priority class
    always_comb begin
        w_res = RES_RUN;
        if (rst) begin
            w_res = RES_RESET;
        end else if (hz.mem_hold) begin
            w_res = RES_HOLD;
        end else if (w_haz) begin
            w_res = RES_STALL;
        end else if (w_redir && !DELAY_SLOT) begin
            w_res = RES_FLUSH;
        end
    end

    // Pipeline control outputs per priority class
    always_comb begin
        w_pc_en       = 1'b1;
        w_ifid_en     = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        unique case (w_res)
            RES_RESET: begin
                w_pc_en       = 1'b0;
                w_ifid_en     = 1'b0;
                w_idex_bubble = 1'b1;
            end
            RES_HOLD: begin
                w_pc_en       = 1'b0;
                w_ifid_en     = 1'b0;
            end
            RES_STALL: begin
                w_pc_en       = 1'b0;
                w_ifid_en     = 1'b0;
                w_idex_bubble = 1'b1;
            end
            RES_FLUSH: begin
                w_ifid_flush  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Entry that enters EX at the next edge; a bubble carries no write
    always_comb begin
        w_sb_ex_nxt = '0;
        if (!w_idex_bubble) begin
            w_sb_ex_nxt.v  = hz.id_valid & hz.id_wrf & (hz.id_wa != '0);
            w_sb_ex_nxt.wa = hz.id_wa;
        end
    end

    // Scoreboard shift; frozen while the memory bus holds the pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sb_ex  <= '0;
            r_sb_mem <= '0;
            r_sb_wb  <= '0;
        end else if (!hz.mem_hold) begin
            r_sb_wb  <= r_sb_mem;
            r_sb_mem <= r_sb_ex;
            r_sb_ex  <= w_sb_ex_nxt;
        end
    end

    // WB entry has no consumer here; kept so it can be probed for debug
    assign w_unused = ^r_sb_wb;

    assign w_stall_inc = (w_res == RES_STALL);
    assign w_flush_inc = (w_res == RES_FLUSH);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_stall_inc),
        .cnt (w_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_flush_inc),
        .cnt (w_flush_cnt)
    );

    assign hz.pc_en       = w_pc_en;
    assign hz.ifid_en     = w_ifid_en;
    assign hz.ifid_flush  = w_ifid_flush;
    assign hz.idex_bubble = w_idex_bubble;
    assign hz.stall_cnt   = w_stall_cnt;
    assign hz.flush_cnt   = w_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three instances share one decode stream
// (no delay slot / delay slot / 4-bit counters); a negedge monitor pops
// expected control vectors from a queue filled as each cycle is driven.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic       use_rs;
        logic [4:0] rt;
        logic       use_rt;
        logic [4:0] wa;
        logic       wrf;
        logic [1:0] pcs;
    } instr_t;

    // Per-cycle stimulus: hold flag plus expected {pc_en, ifid_en, ifid_flush, idex_bubble}
    typedef struct packed {
        logic       hold;
        logic [3:0] exp;
    } cyc_t;

    localparam logic [3:0] C_N = 4'b1100;
    localparam logic [3:0] C_S = 4'b0001;
    localparam logic [3:0] C_H = 4'b0000;
    localparam logic [3:0] C_F = 4'b1110;
    localparam logic [3:0] C_R = 4'b0001;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic [4:0] id_wa;
    logic       id_wrf;
    logic [1:0] id_pcsource;
    logic       mem_hold;

    int checks = 0;
    int errors = 0;

    instr_t     prog_q[$];
    cyc_t       cyc_q[$];
    logic [3:0] exp_q[$];

    pipe_hazard_ctrl_if #(.CNT_W(16)) if_a ();
    pipe_hazard_ctrl_if #(.CNT_W(16)) if_b ();
    pipe_hazard_ctrl_if #(.CNT_W(4))  if_c ();

    assign if_a.id_valid = id_valid;     assign if_b.id_valid = id_valid;     assign if_c.id_valid = id_valid;
    assign if_a.id_rs = id_rs;           assign if_b.id_rs = id_rs;           assign if_c.id_rs = id_rs;
    assign if_a.id_rt = id_rt;           assign if_b.id_rt = id_rt;           assign if_c.id_rt = id_rt;
    assign if_a.id_use_rs = id_use_rs;   assign if_b.id_use_rs = id_use_rs;   assign if_c.id_use_rs = id_use_rs;
    assign if_a.id_use_rt = id_use_rt;   assign if_b.id_use_rt = id_use_rt;   assign if_c.id_use_rt = id_use_rt;
    assign if_a.id_wa = id_wa;           assign if_b.id_wa = id_wa;           assign if_c.id_wa = id_wa;
    assign if_a.id_wrf = id_wrf;         assign if_b.id_wrf = id_wrf;         assign if_c.id_wrf = id_wrf;
    assign if_a.id_pcsource = id_pcsource; assign if_b.id_pcsource = id_pcsource; assign if_c.id_pcsource = id_pcsource;
    assign if_a.mem_hold = mem_hold;     assign if_b.mem_hold = mem_hold;     assign if_c.mem_hold = mem_hold;

    pipe_hazard_ctrl #(.DELAY_SLOT(1'b0), .CNT_W(16)) u_dut (
        .clk (clk), .rst (rst), .hz (if_a)
    );
    pipe_hazard_ctrl #(.DELAY_SLOT(1'b1), .CNT_W(16)) u_ds1 (
        .clk (clk), .rst (rst), .hz (if_b)
    );
    pipe_hazard_ctrl #(.DELAY_SLOT(1'b0), .CNT_W(4)) u_sat (
        .clk (clk), .rst (rst), .hz (if_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic instr_t mk(input logic v, input logic [4:0] rs, input logic urs,
                                  input logic [4:0] rt, input logic urt,
                                  input logic [4:0] wa, input logic wrf, input logic [1:0] pcs);
        instr_t t;
        t.valid = v;   t.rs = rs; t.use_rs = urs; t.rt = rt; t.use_rt = urt;
        t.wa = wa;     t.wrf = wrf; t.pcs = pcs;
        return t;
    endfunction

    task automatic drive_idle();
        id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_wa = 5'd0; id_wrf = 1'b0; id_pcsource = 2'b00; mem_hold = 1'b0;
    endtask

    // Plays cyc_q; IF/ID advances through prog_q only when ifid_en is expected
    task automatic play();
        int     idx = 0;
        cyc_t   e;
        instr_t ins;
        while (cyc_q.size() != 0) begin
            e   = cyc_q.pop_front();
            ins = (idx < prog_q.size()) ? prog_q[idx] : mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00);
            id_valid = ins.valid; id_rs = ins.rs; id_use_rs = ins.use_rs;
            id_rt = ins.rt; id_use_rt = ins.use_rt; id_wa = ins.wa; id_wrf = ins.wrf;
            id_pcsource = ins.pcs; mem_hold = e.hold;
            exp_q.push_back(e.exp);
            @(negedge clk);
            if (e.exp[2]) idx++;
            @(posedge clk);
            #1;
        end
        prog_q.delete();
        drive_idle();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic push_cyc(input logic hold, input logic [3:0] exp);
        cyc_t c;
        c.hold = hold;
        c.exp  = exp;
        cyc_q.push_back(c);
    endtask

    // Scoreboard monitor: compare all three instances against the queued vector
    logic [3:0] mon_exp;
    logic [3:0] mon_a;
    logic [3:0] mon_b;
    logic [3:0] mon_c;
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            mon_a = {if_a.pc_en, if_a.ifid_en, if_a.ifid_flush, if_a.idex_bubble};
            mon_b = {if_b.pc_en, if_b.ifid_en, if_b.ifid_flush, if_b.idex_bubble};
            mon_c = {if_c.pc_en, if_c.ifid_en, if_c.ifid_flush, if_c.idex_bubble};
            checks++;
            if (mon_a !== mon_exp) begin
                errors++;
                $display("FAIL ctrl_ds0 t=%0t got %b exp %b", $time, mon_a, mon_exp);
            end
            checks++;
            if (mon_b !== (mon_exp & 4'b1101)) begin
                errors++;
                $display("FAIL ctrl_ds1 t=%0t got %b exp %b", $time, mon_b, mon_exp & 4'b1101);
            end
            checks++;
            if (mon_c !== mon_exp) begin
                errors++;
                $display("FAIL ctrl_cnt4 t=%0t got %b exp %b", $time, mon_c, mon_exp);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) push_cyc(1'b0, C_R);
        play();
        rst = 1'b0;
        push_cyc(1'b0, C_N);
        play();
        @(negedge clk);
        checks++;
        if (if_a.stall_cnt !== 16'd0 || if_a.flush_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt got stall=%0d flush=%0d exp 0/0", if_a.stall_cnt, if_a.flush_cnt);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_raw_distance();
        apply_reset();
        // distance 0: two stall cycles
        prog_q.push_back(mk(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 2'b00));
        prog_q.push_back(mk(1, 5'd3, 1, 5'd4, 1, 5'd9, 1, 2'b00));
        push_cyc(0, C_N); push_cyc(0, C_S); push_cyc(0, C_S); push_cyc(0, C_N);
        play();
        @(negedge clk);
        checks++;
        if (if_a.stall_cnt !== 16'd2) begin
            errors++; $display("FAIL raw_d0 stall_cnt got %0d exp 2", if_a.stall_cnt);
        end
        @(posedge clk); #1;
        // distance 1: one stall cycle, hazard through rt
        prog_q.push_back(mk(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 2'b00));
        prog_q.push_back(mk(1, 5'd1, 1, 5'd2, 1, 5'd7, 1, 2'b00));
        prog_q.push_back(mk(1, 5'd1, 1, 5'd3, 1, 5'd10, 1, 2'b00));
        push_cyc(0, C_N); push_cyc(0, C_N); push_cyc(0, C_S); push_cyc(0, C_N);
        play();
        @(negedge clk);
        checks++;
        if (if_a.stall_cnt !== 16'd3) begin
            errors++; $display("FAIL raw_d1 stall_cnt got %0d exp 3", if_a.stall_cnt);
        end
        @(posedge clk); #1;
        // distance 2: no stall
        prog_q.push_back(mk(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 2'b00));
        prog_q.push_back(mk(1, 5'd1, 1, 5'd2, 1, 5'd7, 1, 2'b00));
        prog_q.push_back(mk(1, 5'd1, 1, 5'd2, 1, 5'd8, 1, 2'b00));
        prog_q.push_back(mk(1, 5'd3, 1, 5'd0, 0, 5'd11, 1, 2'b00));
        push_cyc(0, C_N); push_cyc(0, C_N); push_cyc(0, C_N); push_cyc(0, C_N);
        play();
        @(negedge clk);
        checks++;
        if (if_a.stall_cnt !== 16'd3 || if_b.stall_cnt !== 16'd3) begin
            errors++; $display("FAIL raw_d2 stall_cnt got %0d/%0d exp 3", if_a.stall_cnt, if_b.stall_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_no_write();
        apply_reset();
        prog_q.push_back(mk(1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 2'b00));  // writes $0
        prog_q.push_back(mk(1, 5'd0, 1, 5'd0, 1, 5'd13, 0, 2'b00));
        prog_q.push_back(mk(1, 5'd1, 1, 5'd2, 1, 5'd5, 0, 2'b00));  // wrf=0
        prog_q.push_back(mk(1, 5'd5, 1, 5'd5, 1, 5'd14, 0, 2'b00));
        prog_q.push_back(mk(1, 5'd1, 1, 5'd2, 1, 5'd6, 1, 2'b00));  // real write
        prog_q.push_back(mk(1, 5'd6, 0, 5'd6, 0, 5'd15, 0, 2'b00)); // does not read it
        prog_q.push_back(mk(0, 5'd1, 1, 5'd2, 1, 5'd12, 1, 2'b00)); // invalid producer
        prog_q.push_back(mk(1, 5'd12, 1, 5'd0, 0, 5'd16, 0, 2'b00));
        repeat (8) push_cyc(0, C_N);
        play();
        @(negedge clk);
        checks++;
        if (if_a.stall_cnt !== 16'd0) begin
            errors++; $display("FAIL no_write stall_cnt got %0d exp 0", if_a.stall_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_redirect();
        apply_reset();
        prog_q.push_back(mk(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 2'b00));
        prog_q.push_back(mk(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b10));
        prog_q.push_back(mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00));
        push_cyc(0, C_N); push_cyc(0, C_F); push_cyc(0, C_N);
        play();
        @(negedge clk);
        checks++;
        if (if_a.flush_cnt !== 16'd1 || if_b.flush_cnt !== 16'd0) begin
            errors++; $display("FAIL redir_single flush_cnt got %0d/%0d exp 1/0", if_a.flush_cnt, if_b.flush_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        prog_q.push_back(mk(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b01));
        prog_q.push_back(mk(1, 5'd0, 0, 5'd0, 0, 5'd31, 1, 2'b11));
        prog_q.push_back(mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00));
        push_cyc(0, C_F); push_cyc(0, C_F); push_cyc(0, C_N);
        play();
        @(negedge clk);
        checks++;
        if (if_a.flush_cnt !== 16'd2 || if_c.flush_cnt !== 4'd2 || if_b.flush_cnt !== 16'd0) begin
            errors++; $display("FAIL redir_b2b flush_cnt got %0d/%0d/%0d exp 2/0/2",
                               if_a.flush_cnt, if_b.flush_cnt, if_c.flush_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall_hold();
        apply_reset();
        prog_q.push_back(mk(1, 5'd29, 1, 5'd0, 0, 5'd8, 1, 2'b00)); // lw $8
        prog_q.push_back(mk(1, 5'd8, 1, 5'd0, 1, 5'd0, 0, 2'b01));  // beq $8,$0
        prog_q.push_back(mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00));
        push_cyc(0, C_N); push_cyc(0, C_S);
        push_cyc(1, C_H); push_cyc(1, C_H); push_cyc(1, C_H);
        push_cyc(0, C_S); push_cyc(0, C_F); push_cyc(0, C_N);
        play();
        @(negedge clk);
        checks++;
        if (if_a.stall_cnt !== 16'd2 || if_a.flush_cnt !== 16'd1) begin
            errors++; $display("FAIL stall_hold cnt got stall=%0d flush=%0d exp 2/1", if_a.stall_cnt, if_a.flush_cnt);
        end
        checks++;
        if (if_b.stall_cnt !== 16'd2 || if_b.flush_cnt !== 16'd0) begin
            errors++; $display("FAIL stall_hold_ds1 cnt got stall=%0d flush=%0d exp 2/0", if_b.stall_cnt, if_b.flush_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        apply_reset();
        prog_q.push_back(mk(1, 5'd0, 0, 5'd0, 0, 5'd1, 1, 2'b00));
        for (int k = 1; k <= 10; k++) begin
            prog_q.push_back(mk(1, 5'(k), 1, 5'd0, 0, 5'(k + 1), 1, 2'b00));
        end
        push_cyc(0, C_N);
        for (int k = 0; k < 10; k++) begin
            push_cyc(0, C_S); push_cyc(0, C_S); push_cyc(0, C_N);
        end
        play();
        @(negedge clk);
        checks++;
        if (if_c.stall_cnt !== 4'd15) begin
            errors++; $display("FAIL sat_cnt4 stall_cnt got %0d exp 15", if_c.stall_cnt);
        end
        checks++;
        if (if_a.stall_cnt !== 16'd20) begin
            errors++; $display("FAIL sat_cnt16 stall_cnt got %0d exp 20", if_a.stall_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_stall();
        apply_reset();
        prog_q.push_back(mk(1, 5'd1, 1, 5'd2, 1, 5'd4, 1, 2'b00));
        prog_q.push_back(mk(1, 5'd4, 1, 5'd0, 0, 5'd9, 1, 2'b00));
        push_cyc(0, C_N); push_cyc(0, C_S);
        play();
        checks++;
        if (if_a.stall_cnt !== 16'd1) begin
            errors++; $display("FAIL mid_pre stall_cnt got %0d exp 1", if_a.stall_cnt);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (if_a.stall_cnt !== 16'd0 || if_c.stall_cnt !== 4'd0) begin
            errors++; $display("FAIL mid_rst stall_cnt got %0d/%0d exp 0", if_a.stall_cnt, if_c.stall_cnt);
        end
        checks++;
        if (if_a.pc_en !== 1'b0 || if_a.idex_bubble !== 1'b1 || if_a.ifid_en !== 1'b0) begin
            errors++; $display("FAIL mid_rst ctrl got pc=%b ifid=%b bub=%b exp 0/0/1",
                               if_a.pc_en, if_a.ifid_en, if_a.idex_bubble);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        // consumer of $4 again: the cleared scoreboard must not stall it
        prog_q.push_back(mk(1, 5'd4, 1, 5'd0, 0, 5'd9, 1, 2'b00));
        push_cyc(0, C_N);
        play();
        @(negedge clk);
        checks++;
        if (if_a.stall_cnt !== 16'd0) begin
            errors++; $display("FAIL mid_post stall_cnt got %0d exp 0", if_a.stall_cnt);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        @(posedge clk);
        #1;
        test_reset();
        test_raw_distance();
        test_no_write();
        test_redirect();
        test_back_to_back();
        test_stall_hold();
        test_saturation();
        test_reset_mid_stall();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline interlock controller for the five-stage CPU. It sits beside the decode stage and tracks the destination registers of instructions in flight through EX, MEM and WB. From that it generates the PC enable, IF/ID enable/flush and ID/EX bubble controls that sequence the fetch/decode datapath. It also resolves read-after-write hazards against the register file, control redirects from the decode-stage branch/jump logic, and external memory-bus holds, and it counts stall and flush events for the LED/segment debug display.

## Interface
- DELAY_SLOT, 1: 1 = the instruction after a branch/jump executes (no flush); 0 = the wrong-path instruction in IF/ID is flushed.
- CNT_W, 16: width of the saturating event counters.

- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  IF/ID holds a real instruction
- id_rs, id_rt  in  5 each  decode source register numbers (instr[25:21], instr[20:16])
- id_use_rs, id_use_rt  in  1 each  instruction actually reads rs / rt
- id_wa  in  5  decode destination register (rd or rt after regwa select)
- id_wrf  in  1  decode register-file write enable
- id_pcsource  in  2  decode PC select; 00 = sequential, non-zero = redirect
- mem_hold  in  1  bus not ready; freeze whole pipeline
- pc_en  out  1  PC register load enable
- ifid_en  out  1  IF/ID register load enable
- ifid_flush  out  1  IF/ID loads NOP at next edge
- idex_bubble  out  1  ID/EX loads NOP (wrf=0, wdmem=0) at next edge
- stall_cnt  out  CNT_W  RAW-stall cycles, saturating
- flush_cnt  out  CNT_W  flushes issued, saturating

## Operation
- Scoreboard: three registered entries {v, wa}: sb_ex, sb_mem, sb_wb.
- Scoreboard advance, each edge with mem_hold=0:
  - sb_wb <= sb_mem
  - sb_mem <= sb_ex
  - sb_ex <= idex_bubble ? {0,0} : {id_valid & id_wrf & (id_wa!=0), id_wa}
- With mem_hold=1 the scoreboard holds.
- RAW hazard:
  - haz = id_valid & ((id_use_rs & id_rs!=0 & match(id_rs)) | (id_use_rt & id_rt!=0 & match(id_rt)))
  - match(r) = (sb_ex.v & sb_ex.wa==r) | (sb_mem.v & sb_mem.wa==r)
  - The register file writes on the falling edge, so sb_wb never causes a hazard. sb_wb is tracked for debug only.
- Redirect: redir = id_valid & (id_pcsource!=0) & ~haz. A redirect computed from stale operands is never acted on.
- Priority (combinational outputs):
  1. rst=1: pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=1.
  2. mem_hold=1: pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=0. ID/EX also holds, because the datapath gates it with mem_hold.
  3. haz=1: pc_en=0, ifid_en=0, idex_bubble=1, ifid_flush=0.
  4. redir=1 and DELAY_SLOT=0: pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=0.
  5. Otherwise: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0.
- Counters, evaluated at the edge:
  - stall_cnt increments when the cycle resolves at priority 3.
  - flush_cnt increments when it resolves at priority 4.
  - Both saturate at 2^CNT_W-1 and never wrap.
  - Neither counts while mem_hold=1.

## Timing
- Reset values: scoreboard all invalid, stall_cnt=0, flush_cnt=0. Outputs take the priority-1 values while rst=1 and the priority-5 values on the first cycle after release (id_valid=0).
- Control outputs are combinational from inputs plus registered scoreboard, with zero latency. Counters update one edge after the event.
- Dependent instruction immediately after a producer: 2 stall cycles. With one independent instruction between: 1 stall cycle. With two between: 0 stall cycles.
- Producer with wa=0 or wrf=0: never stalls a consumer.
- Redirect with DELAY_SLOT=0: exactly 1 flush cycle. Back-to-back redirects each flush.
- Stall then redirect on the same instruction: the flush asserts in the first non-hazard cycle.
- mem_hold mid-stall: freezes the scoreboard, so remaining stall cycles resume after the hold drops.
- rst asserted mid-operation: scoreboard and counters clear immediately (async), with no partial update.

## Structure
- Shared package `pipe_pkg`: pcsource encodings (PC_SEQ=00), NOP instruction constant (32'h0), scoreboard entry typedef {v, wa[4:0]}.
- One sub-module `sat_counter` (parameter W; inputs clk, rst, inc; output cnt), instantiated twice.
- Hazard compare and priority logic are inline.

## Test plan
- Reset: hold rst for 3 cycles, then release with id_valid=0 → pc_en=1, ifid_en=1, idex_bubble=0, ifid_flush=0, both counters 0.
- RAW distance: addu $3 (wa=3) then subu reading rs=3 → exactly 2 cycles of pc_en=0/idex_bubble=1, stall_cnt=2. Repeat with 1 and 2 independent instructions between → stall_cnt increments by 1 and by 0 respectively.
- $0 / no-write producer: producer wa=0, or wrf=0 with wa=5; consumer reads that register → no stall, stall_cnt unchanged.
- Redirect, DELAY_SLOT=0: id_pcsource=01 on a hazard-free instruction → ifid_flush=1 for 1 cycle, flush_cnt=1. With DELAY_SLOT=1 → no flush, flush_cnt=0.
- Stall plus hold: beq depending on a load in EX, with mem_hold pulsed for 3 cycles during the stall → scoreboard frozen, stall_cnt counts only non-hold stall cycles (2), then ifid_flush for 1 cycle.
- Saturation: CNT_W=4, force 20 stall cycles → stall_cnt stops at 15. Assert rst mid-stall → stall_cnt=0 immediately and the scoreboard is cleared.
